// File: rtl/dbreak_arbiter.sv
// Data-break arbiter: picks one of two DMA channels, holds its request to the
// CPU state machine until bk_ack or watchdog expiry, and returns read data.
module dbreak_arbiter #(
  parameter bit RR      = 1'b1,
  parameter int TIMEOUT = 64,
  parameter int TW      = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        req0,
  input  logic        req1,
  input  logic [14:0] addr0,
  input  logic [14:0] addr1,
  input  logic        to_dev0,
  input  logic        to_dev1,
  input  logic [11:0] wdata0,
  input  logic [11:0] wdata1,
  output logic        bk_req,
  output logic [14:0] bk_addr,
  output logic        bk_to_dev,
  output logic [11:0] bk_wdata,
  input  logic        bk_ack,
  input  logic [11:0] bk_rdata,
  output logic [11:0] rdata,
  output logic        done0,
  output logic        done1,
  output logic        err0,
  output logic        err1,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RECOVER
  } state_e;

  localparam logic [TW-1:0] WD_LAST = TW'(TIMEOUT - 1);

  state_e        state_q;
  logic [TW-1:0] wd_q;
  logic          last_q;
  logic          owner_q;
  logic          bk_req_q;
  logic [14:0]   bk_addr_q;
  logic          bk_to_dev_q;
  logic [11:0]   bk_wdata_q;
  logic [11:0]   rdata_q;
  logic [1:0]    done_q;
  logic [1:0]    err_q;
  logic          busy_q;

  logic          any_req;
  logic          win_d;

  // With both channels asking, round-robin favours the one that did not win last.
  always_comb begin
    any_req = req0 | req1;
    if (req0 && req1) win_d = RR ? ~last_q : 1'b0;
    else              win_d = req1;
  end

  // NOTE: every register in this block is assigned with <= so all state
  // updates see the values from before the clock edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      wd_q        <= '0;
      last_q      <= 1'b1;
      owner_q     <= 1'b0;
      bk_req_q    <= 1'b0;
      bk_addr_q   <= '0;
      bk_to_dev_q <= 1'b0;
      bk_wdata_q  <= '0;
      rdata_q     <= '0;
      done_q      <= '0;
      err_q       <= '0;
      busy_q      <= 1'b0;
    end else if (clear) begin
      state_q  <= ST_IDLE;
      wd_q     <= '0;
      bk_req_q <= 1'b0;
      done_q   <= '0;
      err_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      done_q <= '0;
      err_q  <= '0;
      case (state_q)
        ST_IDLE: begin
          if (any_req) begin
            owner_q     <= win_d;
            last_q      <= win_d;
            bk_addr_q   <= win_d ? addr1 : addr0;
            bk_to_dev_q <= win_d ? to_dev1 : to_dev0;
            bk_wdata_q  <= win_d ? wdata1 : wdata0;
            wd_q        <= '0;
            bk_req_q    <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // An ack on the watchdog's last count still completes the cycle.
          if (bk_ack) begin
            rdata_q         <= bk_rdata;
            done_q[owner_q] <= 1'b1;
            bk_req_q        <= 1'b0;
            state_q         <= ST_RECOVER;
          end else if (wd_q == WD_LAST) begin
            err_q[owner_q] <= 1'b1;
            bk_req_q       <= 1'b0;
            state_q        <= ST_RECOVER;
          end else begin
            wd_q <= wd_q + TW'(1);
          end
        end
        ST_RECOVER: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          bk_req_q <= 1'b0;
          busy_q   <= 1'b0;
          state_q  <= ST_IDLE;
        end
      endcase
    end
  end

  assign bk_req    = bk_req_q;
  assign bk_addr   = bk_addr_q;
  assign bk_to_dev = bk_to_dev_q;
  assign bk_wdata  = bk_wdata_q;
  assign rdata     = rdata_q;
  assign done0     = done_q[0];
  assign done1     = done_q[1];
  assign err0      = err_q[0];
  assign err1      = err_q[1];
  assign busy      = busy_q;

endmodule
